// File: rtl/xor_arb_pkg.sv
// Shared definitions for the bit-serial EXOR arbiter.
//   - FSM state encodings (IDLE/RUN/DONE)
//   - default operand width
//   - cnt_width(): bit-counter width, max(1, clog2(width))
package xor_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/xor_serial_arbiter_exor.sv
// Single-bit EXOR cell, the shared datapath element of the serial arbiter.
// Ports:
//   O  - I1 XOR I2
//   I1 - operand bit 1
//   I2 - operand bit 2
module xor_serial_arbiter_exor (
  output logic O,
  input  logic I1,
  input  logic I2
);

  assign O = I1 ^ I2;

endmodule

// File: rtl/xor_serial_arbiter.sv
// Bit-serial XOR controller sharing one EXOR cell between two requesters.
// Round-robin arbitration in IDLE, WIDTH RUN cycles feeding operand bits
// LSB-first through the cell, then a one-cycle DONE with the result.
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   req0/a0/b0 -> ack0  - requester 0 request, operands, accept pulse
//   req1/a1/b1 -> ack1  - requester 1 request, operands, accept pulse
//   busy                - high in RUN and DONE
//   done, done_id       - result-valid pulse and owning requester
//   result              - A XOR B of the owner (valid with done)
//   parity              - reduction XOR of result, only when the
//                         XOR_ARB_PARITY_EN macro is defined
module xor_serial_arbiter #(
  parameter int unsigned WIDTH = xor_arb_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
`ifdef XOR_ARB_PARITY_EN
  ,
  output logic             parity
`endif
);

  import xor_arb_pkg::*;

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
`ifdef XOR_ARB_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic exor_o;
  logic grant0, grant1;

  xor_serial_arbiter_exor u_exor (
    .O  (exor_o),
    .I1 (a_sh_q[0]),
    .I2 (b_sh_q[0])
  );

  // rr_q holds the last served requester; on a tie the other one wins.
  assign grant0 = req0 & (~req1 | rr_q);
  assign grant1 = req1 & (~req0 | ~rr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    result_d  = result_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef XOR_ARB_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_sh_d  = grant0 ? a0 : a1;
          b_sh_d  = grant0 ? b0 : b1;
          owner_d = grant1;
          cnt_d   = '0;
          ack0_d  = grant0;
          ack1_d  = grant1;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef XOR_ARB_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      RUN: begin
        // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
        result_d            = result_q >> 1;
        result_d[WIDTH-1]   = exor_o;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        cnt_d               = cnt_q + CNT_ONE;
`ifdef XOR_ARB_PARITY_EN
        parity_d            = parity_q ^ exor_o;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end
      DONE: begin
        rr_d    = owner_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      result_q  <= '0;
      owner_q   <= 1'b0;
      rr_q      <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef XOR_ARB_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      result_q  <= result_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef XOR_ARB_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
`ifdef XOR_ARB_PARITY_EN
  assign parity  = parity_q;
`endif

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed self-checking bench for xor_serial_arbiter (WIDTH=8 and WIDTH=1).
// Parity checks are included when XOR_ARB_PARITY_EN is defined.
module tb_xor_serial_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, busy, done, done_id;
  logic [7:0] result;

  logic w1_req0 = 1'b0, w1_req1 = 1'b0;
  logic w1_a0 = 1'b0, w1_b0 = 1'b0, w1_a1 = 1'b0, w1_b1 = 1'b0;
  logic w1_ack0, w1_ack1, w1_busy, w1_done, w1_done_id;
  logic w1_result;

`ifdef XOR_ARB_PARITY_EN
  logic parity, w1_parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  initial forever #5 clk = ~clk;

  xor_serial_arbiter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .busy(busy), .done(done), .done_id(done_id), .result(result)
`ifdef XOR_ARB_PARITY_EN
    , .parity(parity)
`endif
  );

  xor_serial_arbiter #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(w1_req0), .a0(w1_a0), .b0(w1_b0), .ack0(w1_ack0),
    .req1(w1_req1), .a1(w1_a1), .b1(w1_b1), .ack1(w1_ack1),
    .busy(w1_busy), .done(w1_done), .done_id(w1_done_id), .result(w1_result)
`ifdef XOR_ARB_PARITY_EN
    , .parity(w1_parity)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0 = 1'b0; req1 = 1'b0; w1_req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Ticks until done is seen; n reports elapsed cycles (40 means timeout).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_checks++; if (ack0 !== 1'b0) $display("FAIL reset_ack0: got %b want 0", ack0); else n_pass++;
    n_checks++; if (ack1 !== 1'b0) $display("FAIL reset_ack1: got %b want 0", ack1); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (done_id !== 1'b0) $display("FAIL reset_done_id: got %b want 0", done_id); else n_pass++;
    n_checks++; if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else n_pass++;
    n_checks++; if (w1_busy !== 1'b0) $display("FAIL reset_w1_busy: got %b want 0", w1_busy); else n_pass++;
`ifdef XOR_ARB_PARITY_EN
    n_checks++; if (parity !== 1'b0) $display("FAIL reset_parity: got %b want 0", parity); else n_pass++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    int n;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req0 = 1'b1;
    tick();
    n_checks++; if (ack0 !== 1'b1) $display("FAIL single_ack0: got %b want 1", ack0); else n_pass++;
    n_checks++; if (ack1 !== 1'b0) $display("FAIL single_ack1: got %b want 0", ack1); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    req0 = 1'b0;
    tick();
    n_checks++; if (ack0 !== 1'b0) $display("FAIL single_ack0_pulse: got %b want 0", ack0); else n_pass++;
    wait_done(n);
    n_checks++; if (n !== 7) $display("FAIL single_latency: got %0d want 7", n); else n_pass++;
    n_checks++; if (done_id !== 1'b0) $display("FAIL single_done_id: got %b want 0", done_id); else n_pass++;
    n_checks++; if (result !== 8'hAA) $display("FAIL single_result: got %h want aa", result); else n_pass++;
`ifdef XOR_ARB_PARITY_EN
    n_checks++; if (parity !== 1'b0) $display("FAIL single_parity: got %b want 0", parity); else n_pass++;
`endif
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== 8'hAA) $display("FAIL single_result_hold: got %h want aa", result); else n_pass++;
  endtask

  task automatic test_operand_change;
    int n;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    a0 = 8'h00;
    wait_done(n);
    n_checks++; if (result !== 8'hAA) $display("FAIL opchg_result: got %h want aa", result); else n_pass++;
  endtask

  task automatic test_simultaneous;
    int n;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; a1 = 8'hFF; b1 = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_checks++; if (ack0 !== 1'b1) $display("FAIL sim_ack0: got %b want 1", ack0); else n_pass++;
    n_checks++; if (ack1 !== 1'b0) $display("FAIL sim_ack1_first: got %b want 0", ack1); else n_pass++;
    req0 = 1'b0;
    wait_done(n);
    n_checks++; if (n !== 8) $display("FAIL sim_latency0: got %0d want 8", n); else n_pass++;
    n_checks++; if (done_id !== 1'b0) $display("FAIL sim_done_id0: got %b want 0", done_id); else n_pass++;
    tick();
    n_checks++; if (ack1 !== 1'b0) $display("FAIL sim_ack1_idle: got %b want 0", ack1); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL sim_busy_idle: got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (ack1 !== 1'b1) $display("FAIL sim_ack1: got %b want 1", ack1); else n_pass++;
    req1 = 1'b0;
    wait_done(n);
    n_checks++; if (done_id !== 1'b1) $display("FAIL sim_done_id1: got %b want 1", done_id); else n_pass++;
    n_checks++; if (result !== 8'hFF) $display("FAIL sim_result1: got %h want ff", result); else n_pass++;
`ifdef XOR_ARB_PARITY_EN
    n_checks++; if (parity !== 1'b0) $display("FAIL sim_parity1: got %b want 0", parity); else n_pass++;
`endif
  endtask

  task automatic test_round_robin;
    int ndone, low, maxlow;
    logic [7:0] exp_r;
    logic       exp_id;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; a1 = 8'hFF; b1 = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    ndone = 0; low = 0; maxlow = 0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      tick();
      if (busy !== 1'b1) low++; else low = 0;
      if (low > maxlow) maxlow = low;
      if (done === 1'b1) begin
        exp_id = (ndone % 2) == 1;
        exp_r  = exp_id ? 8'hFF : 8'hAA;
        n_checks++;
        if (done_id !== exp_id) $display("FAIL rr_done_id[%0d]: got %b want %b", ndone, done_id, exp_id);
        else n_pass++;
        n_checks++;
        if (result !== exp_r) $display("FAIL rr_result[%0d]: got %h want %h", ndone, result, exp_r);
        else n_pass++;
        ndone++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_checks++; if (ndone !== 4) $display("FAIL rr_count: got %0d want 4", ndone); else n_pass++;
    n_checks++; if (maxlow > 1) $display("FAIL rr_busy_gap: got %0d want <=1", maxlow); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int n, pulses;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ack0 !== 1'b0) $display("FAIL midrst_ack0: got %b want 0", ack0); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (result !== 8'h00) $display("FAIL midrst_result: got %h want 00", result); else n_pass++;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL midrst_no_done: got %0d want 0", pulses); else n_pass++;
    a1 = 8'h3C; b1 = 8'h5A; req1 = 1'b1;
    tick();
    n_checks++; if (ack1 !== 1'b1) $display("FAIL midrst_ack1: got %b want 1", ack1); else n_pass++;
    n_checks++; if (ack0 !== 1'b0) $display("FAIL midrst_ack0_later: got %b want 0", ack0); else n_pass++;
    req1 = 1'b0;
    wait_done(n);
    n_checks++; if (n !== 8) $display("FAIL midrst_latency: got %0d want 8", n); else n_pass++;
    n_checks++; if (done_id !== 1'b1) $display("FAIL midrst_done_id: got %b want 1", done_id); else n_pass++;
    n_checks++; if (result !== 8'h66) $display("FAIL midrst_result1: got %h want 66", result); else n_pass++;
  endtask

  task automatic test_width1;
    do_reset();
    w1_a0 = 1'b1; w1_b0 = 1'b1; w1_req0 = 1'b1;
    tick();
    n_checks++; if (w1_ack0 !== 1'b1) $display("FAIL w1_ack0: got %b want 1", w1_ack0); else n_pass++;
    n_checks++; if (w1_ack1 !== 1'b0) $display("FAIL w1_ack1: got %b want 0", w1_ack1); else n_pass++;
    w1_req0 = 1'b0;
    tick();
    n_checks++; if (w1_done !== 1'b1) $display("FAIL w1_done_a: got %b want 1", w1_done); else n_pass++;
    n_checks++; if (w1_result !== 1'b0) $display("FAIL w1_result_a: got %b want 0", w1_result); else n_pass++;
    n_checks++; if (w1_done_id !== 1'b0) $display("FAIL w1_done_id: got %b want 0", w1_done_id); else n_pass++;
    tick();
    n_checks++; if (w1_done !== 1'b0) $display("FAIL w1_done_pulse: got %b want 0", w1_done); else n_pass++;
    w1_a0 = 1'b1; w1_b0 = 1'b0; w1_req0 = 1'b1;
    tick();
    w1_req0 = 1'b0;
    tick();
    n_checks++; if (w1_done !== 1'b1) $display("FAIL w1_done_b: got %b want 1", w1_done); else n_pass++;
    n_checks++; if (w1_result !== 1'b1) $display("FAIL w1_result_b: got %b want 1", w1_result); else n_pass++;
`ifdef XOR_ARB_PARITY_EN
    n_checks++; if (w1_parity !== 1'b1) $display("FAIL w1_parity_b: got %b want 1", w1_parity); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_operand_change();
    test_simultaneous();
    test_round_robin();
    test_reset_mid_run();
    test_width1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
